mmio_rsp_arbiter: RTL
=====================

// Module: mmio_rsp_arbiter
// PURPOSE
//   Shares the single CCI-P MMIO read-response channel (TX c2) between N_REQ CSR sub-blocks.
//   Each sub-block posts a read response (tid, data) into its own 1-deep holding register.
//   A round-robin arbiter drains one held response per cycle into a registered c2 output.
//   Sits between per-function CSR decoders and af2cp_sTxPort.c2 in the AFU top level.
// PARAMETERS
//   N_REQ   4   number of requesters; legal range 2..8
//   TID_W   9   MMIO transaction-id width (CCI-P tid)
//   DATA_W  64  response data width
// PORTS
//   clk            in   1             interface clock
//   rst            in   1             reset: asynchronous, active-high
//   req_valid      in   N_REQ         requester i presents a response
//   req_tid        in   N_REQ*TID_W   tid of requester i, slice [i*TID_W +: TID_W]
//   req_data       in   N_REQ*DATA_W  data of requester i, slice [i*DATA_W +: DATA_W]
//   req_ready      out  N_REQ         requester i accepted when req_valid[i] & req_ready[i] at posedge
//   rsp_valid      out  1             drives af2cp_sTxPort.c2.mmioRdValid
//   rsp_tid        out  TID_W         drives c2.hdr.tid
//   rsp_data       out  DATA_W        drives c2.data
//   stat_clr       in   1             clears statistics counters; present only with MMIO_RSP_ARB_STATS_EN
//   stat_rsp_cnt   out  32            responses issued; present only with MMIO_RSP_ARB_STATS_EN
//   stat_conf_cnt  out  32            contention cycles; present only with MMIO_RSP_ARB_STATS_EN
// BEHAVIOUR
//   - Reset (async assert; release is synchronised by the top level):
//       hold_vld = 0; rr_ptr = 0; rsp_valid = 0; rsp_tid = 0; rsp_data = 0; stat counters = 0.
//   - Holding register i: hold_vld[i], hold_tid[i], hold_data[i].
//   - req_ready[i] = ~hold_vld[i] | gnt[i] (combinational).
//     A grant and a new accept on the same requester in one cycle:
//     old entry drains, new entry loads, no bubble.
//   - Accept at edge E loads the holding register. The grant is evaluated in the cycle after E.
//     rsp_valid is high in the cycle after that edge.
//     Minimum latency is 2 cycles from req_valid sampled to rsp_valid.
//   - Arbitration (combinational):
//       gnt = first i with hold_vld[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//       At most one bit of gnt is set.
//   - On a grant to i at an edge:
//       rsp_valid <= 1; rsp_tid <= hold_tid[i]; rsp_data <= hold_data[i];
//       hold_vld[i] cleared unless reloaded; rr_ptr <= (i+1) mod N_REQ.
//   - No grant: rsp_valid <= 0. rsp_tid and rsp_data hold their last value. rr_ptr unchanged.
//   - rsp_valid is a single-cycle pulse per response. c2 has no backpressure.
//     Throughput is 1 response/cycle when any hold_vld is set.
//   - No response is ever dropped or duplicated. A requester holding an entry is served
//     within N_REQ cycles (round-robin starvation bound).
//   - Responses leave in grant order, not arrival order. tid carries the association.
//   - req_valid without req_ready: the requester must hold req_valid, tid and data stable.
//     Behaviour is undefined if it does not.
//   - Reset mid-operation: all held responses are discarded and rsp_valid drops immediately (async).
//     The host MMIO timeout covers lost reads.
// CONFIGURATION
//   MMIO_RSP_ARB_STATS_EN defined:
//     - stat_rsp_cnt increments on every rsp_valid set; wraps at 2^32.
//     - stat_conf_cnt increments in each cycle with >1 hold_vld bit set; saturates at 32'hFFFF_FFFF.
//     - stat_clr = 1 zeroes both counters at the next edge, with priority over increment.
//   MMIO_RSP_ARB_STATS_EN undefined: the stat ports and their logic are absent;
//     the arbitration datapath is identical.
// TESTING
//   1 single: cycle 0 req_valid=4'b0001, tid=9'h011, data=64'hA5
//       -> rsp_valid high in cycle 2 only, tid 9'h011, data 64'hA5.
//   2 all four load together at one edge with tids 1..4, rr_ptr=0
//       -> rsp tids 1,2,3,4 on four consecutive cycles; then rsp_valid=0.
//   3 fairness: rr_ptr=3 after grant to 2; requesters 0 and 3 pending
//       -> 3 served first, then 0; rr_ptr ends at 1.
//   4 streaming: requester 1 posts every cycle (tid 0..7) while 2 holds tid 9'h1FF
//       -> 9'h1FF issued within 2 cycles; all 9 tids appear exactly once; req_ready[1] never stalls >1 cycle.
//   5 reset: assert rst with 3 entries held and rsp_valid=1
//       -> rsp_valid=0 asynchronously; after release no response issues without new requests.
//   6 stats (MMIO_RSP_ARB_STATS_EN): scenario 2, then stat_clr
//       -> stat_rsp_cnt=4 and stat_conf_cnt=3 before clear; both 0 after.

Source files
------------

// File: rtl/mmio_rsp_arbiter.sv
// Round-robin arbiter sharing the CCI-P MMIO read-response channel (c2) between N_REQ CSR blocks.
// Optional statistics counters are built when MMIO_RSP_ARB_STATS_EN is defined.
module mmio_rsp_arbiter #(
   parameter int N_REQ  = 4,
   parameter int TID_W  = 9,
   parameter int DATA_W = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*TID_W-1:0]    req_tid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      rsp_valid,
   output logic [TID_W-1:0]          rsp_tid,
   output logic [DATA_W-1:0]         rsp_data
`ifdef MMIO_RSP_ARB_STATS_EN
   ,
   input  logic                      stat_clr,
   output logic [31:0]               stat_rsp_cnt,
   output logic [31:0]               stat_conf_cnt
`endif
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [TID_W-1:0]  in_tid  [N_REQ];
   logic [DATA_W-1:0] in_data [N_REQ];

   logic [N_REQ-1:0]  hold_vld_q, hold_vld_d;
   logic [TID_W-1:0]  hold_tid_q  [N_REQ];
   logic [TID_W-1:0]  hold_tid_d  [N_REQ];
   logic [DATA_W-1:0] hold_data_q [N_REQ];
   logic [DATA_W-1:0] hold_data_d [N_REQ];

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [TID_W-1:0]  rsp_tid_q, rsp_tid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic [N_REQ-1:0]  gnt;
   logic [PTR_W-1:0]  gnt_idx;
   logic              gnt_any;
   int                scan_idx;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slot
         assign in_tid[gi]    = req_tid[gi*TID_W +: TID_W];
         assign in_data[gi]   = req_data[gi*DATA_W +: DATA_W];
         // A slot being drained this cycle can take a new entry with no bubble.
         assign req_ready[gi] = ~hold_vld_q[gi] | gnt[gi];
      end
   endgenerate

   // First held slot at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      gnt_any  = 1'b0;
      scan_idx = 0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!gnt_any && hold_vld_q[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(scan_idx);
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   always_comb begin
      hold_vld_d  = hold_vld_q;
      hold_tid_d  = hold_tid_q;
      hold_data_d = hold_data_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            hold_vld_d[i]  = 1'b1;
            hold_tid_d[i]  = in_tid[i];
            hold_data_d[i] = in_data[i];
         end else if (gnt[i]) begin
            hold_vld_d[i]  = 1'b0;
         end
      end

      rsp_valid_d = gnt_any;
      rsp_tid_d   = rsp_tid_q;
      rsp_data_d  = rsp_data_q;
      rr_ptr_d    = rr_ptr_q;
      if (gnt_any) begin
         rsp_tid_d  = hold_tid_q[gnt_idx];
         rsp_data_d = hold_data_q[gnt_idx];
         rr_ptr_d   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_vld_q  <= '0;
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            hold_tid_q[i]  <= '0;
            hold_data_q[i] <= '0;
         end
      end else begin
         hold_vld_q  <= hold_vld_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
         rsp_data_q  <= rsp_data_d;
         for (int i = 0; i < N_REQ; i++) begin
            hold_tid_q[i]  <= hold_tid_d[i];
            hold_data_q[i] <= hold_data_d[i];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_tid   = rsp_tid_q;
   assign rsp_data  = rsp_data_q;

`ifdef MMIO_RSP_ARB_STATS_EN
   logic [31:0] rsp_cnt_q, rsp_cnt_d;
   logic [31:0] conf_cnt_q, conf_cnt_d;
   logic [3:0]  held_cnt;

   always_comb begin
      held_cnt = '0;
      for (int i = 0; i < N_REQ; i++) held_cnt = held_cnt + 4'(hold_vld_q[i]);

      rsp_cnt_d  = rsp_cnt_q;
      conf_cnt_d = conf_cnt_q;
      if (stat_clr) begin
         rsp_cnt_d  = '0;
         conf_cnt_d = '0;
      end else begin
         if (rsp_valid_d) rsp_cnt_d = rsp_cnt_q + 32'd1;
         // Contention counter saturates rather than wrapping.
         if (held_cnt > 4'd1 && conf_cnt_q != 32'hFFFF_FFFF) conf_cnt_d = conf_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_cnt_q  <= '0;
         conf_cnt_q <= '0;
      end else begin
         rsp_cnt_q  <= rsp_cnt_d;
         conf_cnt_q <= conf_cnt_d;
      end
   end

   assign stat_rsp_cnt  = rsp_cnt_q;
   assign stat_conf_cnt = conf_cnt_q;
`endif

endmodule
